reg_file_sync: RTL and testbench

Parametrised multi-read-port register file for the RISC-V datapath: a bank of DEPTH enabled, resettable registers of WIDTH bits. It has one synchronous write port and NUM_RD combinational read ports. Register 0 is optionally hardwired to zero, and write-to-read bypass is selectable. It sits between decode (read addresses) and writeback (write port) and generalises the single enabled D flip-flop into an addressed array.

---
 rtl/rv_pkg.sv | 11 +
 rtl/dff_sync_reset.sv | 20 ++
 rtl/reg_file_sync.sv | 65 ++++++
 tb/tb_reg_file_sync.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared datapath constants and types for the RISC-V core.
package rv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_COUNT  = 32;
  localparam int unsigned REG_ADDR_W = $clog2(REG_COUNT);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

endpackage

// File: rtl/dff_sync_reset.sv
// Single enabled register with synchronous active-high reset; reset beats enable.
module dff_sync_reset #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (wr_en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_file_sync.sv
// Register file: one synchronous write port, NUM_RD combinational read ports,
// optional hardwired zero register and optional write-to-read bypass.
module reg_file_sync
  import rv_pkg::*;
#(
  parameter int unsigned WIDTH    = XLEN,
  parameter int unsigned DEPTH    = REG_COUNT,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned AW      = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [AW-1:0]                 wr_addr,
  input  logic [WIDTH-1:0]              wr_data,
  input  logic [NUM_RD-1:0][AW-1:0]     rd_addr,
  output logic [NUM_RD-1:0][WIDTH-1:0]  rd_data
);

  localparam int unsigned FIRST = ZERO_REG ? 1 : 0;

  logic [WIDTH-1:0] regs [DEPTH];
  logic             wr_ok;

  // A write that will actually land at the next edge; also qualifies bypass.
  assign wr_ok = wr_en && !rst && (32'(wr_addr) < DEPTH)
                 && !(ZERO_REG && (wr_addr == '0));

  if (ZERO_REG) begin : g_zero
    assign regs[0] = '0;
  end

  for (genvar i = FIRST; i < DEPTH; i++) begin : g_reg
    dff_sync_reset #(
      .WIDTH (WIDTH)
    ) u_reg (
      .clk   (clk),
      .rst   (rst),
      .wr_en (wr_en && (wr_addr == AW'(i))),
      .d     (wr_data),
      .q     (regs[i])
    );
  end

  // Per-port read mux: range check, then zero register, then bypass.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [WIDTH-1:0] val;

    always_comb begin
      val = '0;
      if ((32'(rd_addr[p]) < DEPTH) && !(ZERO_REG && (rd_addr[p] == '0))) begin
        if (BYPASS && wr_ok && (wr_addr == rd_addr[p])) begin
          val = wr_data;
        end else begin
          val = regs[rd_addr[p]];
        end
      end
    end

    assign rd_data[p] = val;
  end

endmodule

// File: tb/tb_reg_file_sync.sv
// Self-checking bench: three register file configurations share one write port
// and are compared against array models every cycle.
module tb_reg_file_sync;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  logic [1:0][4:0]  ra_a;
  logic [1:0][31:0] rd_a;
  logic [2:0][4:0]  ra_b;
  logic [2:0][31:0] rd_b;
  logic [0:0][4:0]  ra_c;
  logic [0:0][31:0] rd_c;

  logic [31:0] m_a [32];
  logic [31:0] m_b [32];
  logic [31:0] m_c [32];

  int n_checks = 0;
  int n_fail   = 0;

  // a: default (ZERO_REG=1, BYPASS=1, 2 ports)
  reg_file_sync #(.WIDTH(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(ra_a), .rd_data(rd_a));

  // b: ZERO_REG=0, BYPASS=0, 3 ports
  reg_file_sync #(.WIDTH(32), .DEPTH(32), .NUM_RD(3), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(ra_b), .rd_data(rd_b));

  // c: DEPTH=20, 1 port, bypass on
  reg_file_sync #(.WIDTH(32), .DEPTH(20), .NUM_RD(1), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_c (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(ra_c), .rd_data(rd_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit write_lands(input int depth, input bit zr);
    return !rst && wr_en && (int'(wr_addr) < depth) && !(zr && wr_addr == 5'd0);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] m [32], input int depth,
                                         input bit zr, input bit bp, input logic [4:0] a);
    if (int'(a) >= depth) return 32'd0;
    if (zr && a == 5'd0) return 32'd0;
    if (bp && write_lands(depth, zr) && wr_addr == a) return wr_data;
    return m[a];
  endfunction

  task automatic check_all(input string tag);
    for (int p = 0; p < 2; p++)
      check($sformatf("%s a%0d r%0d", tag, p, ra_a[p]), rd_a[p], exp_rd(m_a, 32, 1'b1, 1'b1, ra_a[p]));
    for (int p = 0; p < 3; p++)
      check($sformatf("%s b%0d r%0d", tag, p, ra_b[p]), rd_b[p], exp_rd(m_b, 32, 1'b0, 1'b0, ra_b[p]));
    check($sformatf("%s c0 r%0d", tag, ra_c[0]), rd_c[0], exp_rd(m_c, 20, 1'b1, 1'b1, ra_c[0]));
  endtask

  task automatic update_models();
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_a[i] = '0; m_b[i] = '0; m_c[i] = '0;
      end
    end else begin
      if (write_lands(32, 1'b1)) m_a[wr_addr] = wr_data;
      if (write_lands(32, 1'b0)) m_b[wr_addr] = wr_data;
      if (write_lands(20, 1'b1)) m_c[wr_addr] = wr_data;
    end
  endtask

  // Caller has driven inputs and settled #1; check, clock, update models.
  task automatic tick(input string tag);
    check_all(tag);
    @(posedge clk);
    update_models();
    @(negedge clk);
  endtask

  task automatic set_ra(input logic [4:0] a);
    ra_a = {a, a}; ra_b = {a, a, a}; ra_c[0] = a;
  endtask

  task automatic drive(input bit r, input bit we, input logic [4:0] wa, input logic [31:0] wd);
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
  endtask

  initial begin
    drive(1'b1, 1'b0, 5'd0, 32'd0);
    set_ra(5'd0);
    for (int i = 0; i < 32; i++) begin
      m_a[i] = '0; m_b[i] = '0; m_c[i] = '0;
    end
    @(posedge clk);
    @(negedge clk);

    // Reset state
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    for (int a = 0; a < 32; a += 7) begin
      set_ra(5'(a));
      #1;
      check("reset_state", rd_b[1], 32'd0);
      tick("reset_state");
    end

    // Fill, then reset with a colliding write
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b1, 5'(i), 32'hA5A5_0000 + 32'(i));
      set_ra(5'(i));
      #1;
      tick("fill");
    end
    set_ra(5'd3);
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    #1;
    check("filled_r3", rd_b[2], 32'hA5A5_0003);
    tick("filled");
    drive(1'b1, 1'b1, 5'd3, 32'hCAFE_F00D);
    #1;
    check("rst_reads_stored", rd_a[0], 32'hA5A5_0003);
    tick("in_reset");
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    for (int a = 0; a < 32; a++) begin
      set_ra(5'(a));
      #1;
      if (a == 3) check("write_in_rst_lost", rd_b[0], 32'd0);
      tick("after_reset");
    end

    // Latency without bypass (b) and bypass (a)
    set_ra(5'd5);
    drive(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    #1;
    check("nobyp_old", rd_b[0], 32'd0);
    check("byp_new", rd_a[0], 32'hDEAD_BEEF);
    tick("lat");
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    #1;
    check("nobyp_next", rd_b[0], 32'hDEAD_BEEF);
    tick("lat_next");

    set_ra(5'd7);
    drive(1'b0, 1'b1, 5'd7, 32'h1234_5678);
    #1;
    check("byp_p0", rd_a[0], 32'h1234_5678);
    check("byp_p1", rd_a[1], 32'h1234_5678);
    tick("byp");
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    #1;
    check("byp_persist", rd_a[1], 32'h1234_5678);
    tick("byp_persist");

    // Zero register
    set_ra(5'd0);
    drive(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    #1;
    check("zero_wcycle", rd_a[0], 32'd0);
    check("zero_wcycle_c", rd_c[0], 32'd0);
    tick("zero");
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    #1;
    check("zero_after", rd_a[1], 32'd0);
    check("nozero_after", rd_b[2], 32'hFFFF_FFFF);
    tick("zero_after");

    // Out of range on DEPTH=20
    drive(1'b0, 1'b1, 5'd9, 32'h0000_0099);
    set_ra(5'd9);
    #1;
    tick("oor_setup");
    drive(1'b0, 1'b1, 5'd25, 32'h0000_0055);
    set_ra(5'd25);
    #1;
    check("oor_read_wcycle", rd_c[0], 32'd0);
    tick("oor");
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    #1;
    check("oor_read", rd_c[0], 32'd0);
    tick("oor_read");
    set_ra(5'd9);
    #1;
    check("oor_r9_kept", rd_c[0], 32'h0000_0099);
    tick("oor_r9");

    // Random regression
    for (int cyc = 0; cyc < 10000; cyc++) begin
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 1) == 1),
            5'($urandom_range(0, 31)), $urandom);
      for (int p = 0; p < 2; p++) ra_a[p] = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      for (int p = 0; p < 3; p++) ra_b[p] = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      ra_c[0] = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      #1;
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
